// File: rtl/pm_axil_pkg.sv
// pm_axil_pkg: shared types and constants for the PM AXI4-Lite arbiter.
//   state_t      - sequencer states of pm_axil_arbiter
//   RESP_*       - AXI response codes
//   PROT_DEFAULT - AxPROT value driven on every transaction
//   PM_REG0..3   - byte offsets of the four PM peripheral registers
package pm_axil_pkg;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [2:0]  PROT_DEFAULT = 3'b000;

    localparam logic [31:0] PM_REG0 = 32'h0;
    localparam logic [31:0] PM_REG1 = 32'h4;
    localparam logic [31:0] PM_REG2 = 32'h8;
    localparam logic [31:0] PM_REG3 = 32'hC;

endpackage

// File: rtl/pm_rr_arb2.sv
// pm_rr_arb2: two-way round-robin arbiter with a registered last-grant pointer.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req         - request vector (bit i = requester i)
//   take        - the current grant is being consumed; remember it
//   grant_valid - at least one request present
//   grant       - index of the winning requester (combinational)
module pm_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant_valid,
    output logic       grant
);

    logic last_grant;

    // A tie goes to whoever was not served last; a lone request always wins.
    always_comb grant_valid = |req;
    always_comb grant = (req == 2'b11) ? ~last_grant : req[1];

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last_grant <= 1'b1;
        else if (take)
            last_grant <= grant;

endmodule

// File: rtl/pm_axil_arbiter.sv
// pm_axil_arbiter: shares one AXI4-Lite master port between two requesters,
// one single-word transaction at a time, round-robin arbitrated.
//   ACLK, ARESETN              - clock, asynchronous active-low reset
//   req_valid/write/addr/wdata - per-requester command (slice i = requester i)
//   req_ready                  - one-hot command-accept pulse
//   rsp_valid/rdata/resp       - one-cycle response to the granted requester
//   M_AXI_*                    - AXI4-Lite master channels (AW, W, B, AR, R)
module pm_axil_arbiter
    import pm_axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    state_t              state;
    logic                owner;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic                grant_valid;
    logic                grant;
    logic                take;
    logic                aw_done;
    logic                w_done;

    assign M_AXI_AWADDR = addr;
    assign M_AXI_ARADDR = addr;
    assign M_AXI_WDATA  = wdata;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_AWPROT = PROT_DEFAULT;
    assign M_AXI_ARPROT = PROT_DEFAULT;

    // Arbitration runs in IDLE and also in the RSP cycle, so back-to-back
    // commands are granted the cycle right after the response pulse.
    always_comb take = grant_valid && (state == IDLE || state == RSP);

    // A channel is finished once it is not (or no longer) presenting valid.
    always_comb aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    always_comb w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

    pm_rr_arb2 u_arb (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .req         (req_valid),
        .take        (take),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // req_ready is high only in the first cycle after a grant; the channel
    // states use it to raise their VALIDs one cycle after the grant cycle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            owner         <= 1'b0;
            addr          <= '0;
            wdata         <= '0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE, RSP: begin
                    if (grant_valid) begin
                        req_ready <= grant ? 2'b10 : 2'b01;
                        owner     <= grant;
                        addr      <= grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                        wdata     <= grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        state     <= req_write[grant] ? WR : RD_A;
                    end else begin
                        state <= IDLE;
                    end
                end
                WR: begin
                    if (|req_ready) begin
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                    end else begin
                        if (M_AXI_AWREADY)
                            M_AXI_AWVALID <= 1'b0;
                        if (M_AXI_WREADY)
                            M_AXI_WVALID <= 1'b0;
                        if (aw_done && w_done) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= WR_B;
                        end
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_valid    <= owner ? 2'b10 : 2'b01;
                        state        <= RSP;
                    end
                end
                RD_A: begin
                    if (|req_ready) begin
                        M_AXI_ARVALID <= 1'b1;
                    end else if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_R;
                    end
                end
                RD_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_valid    <= owner ? 2'b10 : 2'b01;
                        state        <= RSP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
